fpu_issue_ctrl: RTL and testbench

// - Core-side counterpart of the FPU: accepts decoded FP ops from the integer pipeline, checks

---
 rtl/fpu_issue_ctrl_pkg.sv | 18 +
 rtl/fpu_scoreboard.sv | 25 ++
 rtl/fpu_issue_ctrl.sv | 104 ++++++++++
 tb/tb_fpu_issue_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_issue_ctrl_pkg: shared FP issue types and issue-controller state encoding
package fpu_issue_ctrl_pkg;
  typedef enum logic [1:0] {ISS_IDLE, ISS_WAIT, ISS_WB} iss_state_t;
  typedef struct packed {
    logic       fwren;
    logic       wren;
    logic [4:0] waddr;
    logic       fpuf;
  } fp_issue_in_type;
  typedef struct packed {
    logic        fp_wren;
    logic        int_wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_fpu;
    logic [4:0]  fflags;
  } fp_issue_out_type;
endpackage

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: pending FP destination vector with three-source hazard lookup
module fpu_scoreboard (
  input  logic       clock,
  input  logic       reset,
  input  logic       set,
  input  logic [4:0] set_addr,
  input  logic       clr,
  input  logic [4:0] clr_addr,
  input  logic       clr_all,
  input  logic [2:0] rden,
  input  logic [4:0] raddr1,
  input  logic [4:0] raddr2,
  input  logic [4:0] raddr3,
  output logic       hazard
);
  logic [31:0] pend;
  always_ff @(posedge clock) begin
    if (reset || clr_all) pend <= '0;
    else begin
      if (clr) pend[clr_addr] <= 1'b0;
      if (set) pend[set_addr] <= 1'b1;
    end
  end
  assign hazard = (rden[0] & pend[raddr1]) | (rden[1] & pend[raddr2]) | (rden[2] & pend[raddr3]);
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-op-in-flight FP issue, hazard check, execute handshake and write-back
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic        iss_fwren,
  input  logic        iss_wren,
  input  logic [4:0]  iss_waddr,
  input  logic [2:0]  iss_rden,
  input  logic [4:0]  iss_raddr1,
  input  logic [4:0]  iss_raddr2,
  input  logic [4:0]  iss_raddr3,
  input  logic        iss_fpuf,
  input  logic        iss_multi,
  output logic        exe_start,
  input  logic        exe_ready,
  input  logic [31:0] exe_result,
  input  logic [4:0]  exe_flags,
  output logic        fp_wren,
  output logic [4:0]  fp_waddr,
  output logic [31:0] fp_wdata,
  output logic        int_wren,
  output logic [4:0]  int_waddr,
  output logic [31:0] int_wdata,
  output logic        csr_fpu,
  output logic [4:0]  csr_fflags,
  input  logic [4:0]  csr_fflags_cur,
  output logic        busy,
  output logic        err
);
  iss_state_t       state, next;
  fp_issue_in_type  iss_in, op_q;
  fp_issue_out_type wb_out;
  logic [31:0]      data_q;
  logic [4:0]       flags_q;
  logic [15:0]      wait_cnt;
  logic             hazard, accept, wb;
  assign iss_in    = '{fwren: iss_fwren, wren: iss_wren, waddr: iss_waddr, fpuf: iss_fpuf};
  assign iss_ready = ~reset & (state == ISS_IDLE) & ~flush & ~hazard;
  assign accept    = iss_valid & iss_ready;
  assign exe_start = accept;
  assign busy      = state != ISS_IDLE;
  assign wb        = (state == ISS_WB) & ~flush;
  assign err       = (MAX_WAIT != 0) && (state == ISS_WAIT) && (wait_cnt == 16'(MAX_WAIT - 1));
  always_comb begin
    next = state;
    if (state == ISS_IDLE && accept) next = iss_multi ? ISS_WAIT : ISS_WB;
    if (state == ISS_WAIT && exe_ready) next = ISS_WB;
    if (state == ISS_WB) next = ISS_IDLE;
    if (flush) next = ISS_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ISS_IDLE;
      op_q     <= '0;
      data_q   <= '0;
      flags_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= next;
      if (accept) op_q <= iss_in;
      if ((accept && !iss_multi) || (state == ISS_WAIT && exe_ready)) begin
        data_q  <= exe_result;
        flags_q <= exe_flags;
      end
      // counter saturates so the timeout pulse fires exactly once per WAIT stay
      wait_cnt <= (state != ISS_WAIT) ? '0 : (wait_cnt < 16'(MAX_WAIT)) ? wait_cnt + 16'd1 : wait_cnt;
    end
  end
  fpu_scoreboard u_sb (
    .clock    (clock),
    .reset    (reset),
    .set      (accept & iss_fwren),
    .set_addr (iss_waddr),
    .clr      (wb & op_q.fwren),
    .clr_addr (op_q.waddr),
    .clr_all  (flush),
    .rden     (iss_rden),
    .raddr1   (iss_raddr1),
    .raddr2   (iss_raddr2),
    .raddr3   (iss_raddr3),
    .hazard   (hazard)
  );
  assign wb_out = '{fp_wren:  wb & op_q.fwren,
                    int_wren: wb & op_q.wren,
                    waddr:    op_q.waddr,
                    wdata:    data_q,
                    csr_fpu:  wb & op_q.fpuf,
                    fflags:   (wb & op_q.fpuf) ? (csr_fflags_cur | flags_q) : 5'd0};
  assign fp_wren    = wb_out.fp_wren;
  assign fp_waddr   = wb_out.waddr;
  assign fp_wdata   = wb_out.wdata;
  assign int_wren   = wb_out.int_wren;
  assign int_waddr  = wb_out.waddr;
  assign int_wdata  = wb_out.wdata;
  assign csr_fpu    = wb_out.csr_fpu;
  assign csr_fflags = wb_out.fflags;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed vectors for issue, hazard, flush, timeout and write-back
module tb_fpu_issue_ctrl;
  logic        clock = 0, reset = 1, flush = 0, iss_valid = 0;
  logic        iss_fwren = 0, iss_wren = 0, iss_fpuf = 0, iss_multi = 0, exe_ready = 0;
  logic [4:0]  iss_waddr = 0, iss_raddr1 = 0, iss_raddr2 = 0, iss_raddr3 = 0;
  logic [2:0]  iss_rden = 0;
  logic [31:0] exe_result = 0;
  logic [4:0]  exe_flags = 0, csr_fflags_cur = 0;
  logic        iss_ready, exe_start, fp_wren, int_wren, csr_fpu, busy, err;
  logic [4:0]  fp_waddr, int_waddr, csr_fflags;
  logic [31:0] fp_wdata, int_wdata;
  int n_tests = 0, n_fail = 0, starts = 0;
  fpu_issue_ctrl #(.MAX_WAIT(8)) dut (
    .clock(clock), .reset(reset), .flush(flush), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_fwren(iss_fwren), .iss_wren(iss_wren), .iss_waddr(iss_waddr), .iss_rden(iss_rden),
    .iss_raddr1(iss_raddr1), .iss_raddr2(iss_raddr2), .iss_raddr3(iss_raddr3),
    .iss_fpuf(iss_fpuf), .iss_multi(iss_multi), .exe_start(exe_start), .exe_ready(exe_ready),
    .exe_result(exe_result), .exe_flags(exe_flags), .fp_wren(fp_wren), .fp_waddr(fp_waddr),
    .fp_wdata(fp_wdata), .int_wren(int_wren), .int_waddr(int_waddr), .int_wdata(int_wdata),
    .csr_fpu(csr_fpu), .csr_fflags(csr_fflags), .csr_fflags_cur(csr_fflags_cur),
    .busy(busy), .err(err)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic adv;
    @(posedge clock);
    #1;
  endtask
  task automatic settle;
    #2;
  endtask
  task automatic clr_in;
    iss_valid = 0; iss_fwren = 0; iss_wren = 0; iss_waddr = 0; iss_rden = 0;
    iss_raddr1 = 0; iss_raddr2 = 0; iss_raddr3 = 0; iss_fpuf = 0; iss_multi = 0;
  endtask
  task automatic issue(input logic fw, input logic w, input logic [4:0] wa, input logic [2:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic fu, input logic mu);
    iss_valid = 1; iss_fwren = fw; iss_wren = w; iss_waddr = wa; iss_rden = rd;
    iss_raddr1 = r1; iss_raddr2 = r2; iss_raddr3 = 0; iss_fpuf = fu; iss_multi = mu;
  endtask
  initial begin
    // reset: outputs quiet even with a valid op and live fflags present
    iss_valid = 1; csr_fflags_cur = 5'h1f;
    adv; settle;
    check("rst_ready", iss_ready, 0);
    check("rst_start", exe_start, 0);
    check("rst_busy", busy, 0);
    check("rst_fp_wren", fp_wren, 0);
    check("rst_fflags", csr_fflags, 0);
    adv; reset = 0; iss_valid = 0; csr_fflags_cur = 0; settle;
    check("rst_release_ready", iss_ready, 1);
    // fadd f3 <- f1,f2: result sampled at accept, written next cycle
    adv; issue(1, 0, 3, 3'b011, 1, 2, 0, 0); exe_result = 32'h40400000; settle;
    check("fadd_ready", iss_ready, 1);
    check("fadd_start", exe_start, 1);
    adv; clr_in; exe_result = 32'hdeadbeef; settle;
    check("fadd_wren", fp_wren, 1);
    check("fadd_waddr", fp_waddr, 3);
    check("fadd_wdata", fp_wdata, 32'h40400000);
    check("fadd_int_wren", int_wren, 0);
    check("fadd_wb_ready", iss_ready, 0);
    check("fadd_csr", csr_fpu, 0);
    adv; settle;
    check("fadd_idle_ready", iss_ready, 1);
    check("fadd_once", fp_wren, 0);
    // fdiv f5, dependent reader of f5 stalls until write-back completes
    adv; issue(1, 0, 5, 3'b011, 1, 2, 1, 1); exe_flags = 5'b00100; csr_fflags_cur = 5'b00010; settle;
    starts = exe_start;
    for (int c = 1; c <= 13; c++) begin
      adv;
      if (c == 1) clr_in;
      if (c == 2) issue(1, 0, 6, 3'b001, 5, 0, 0, 0);
      exe_ready  = (c == 12);
      exe_result = (c == 12) ? 32'h3f000000 : 32'hbad00000;
      exe_flags  = (c == 12) ? 5'b01000 : 5'b11111;
      settle;
      starts += exe_start;
      check("fdiv_busy", busy, 1);
      check("fdiv_err", err, (c == 8) ? 1 : 0);
      check("fdiv_wren", fp_wren, (c == 13) ? 1 : 0);
      if (c >= 2) check("fdiv_hazard", iss_ready, 0);
    end
    check("fdiv_waddr", fp_waddr, 5);
    check("fdiv_wdata", fp_wdata, 32'h3f000000);
    check("fdiv_csr", csr_fpu, 1);
    check("fdiv_fflags", csr_fflags, 5'b01010);
    check("fdiv_starts", starts, 1);
    adv; exe_ready = 0; exe_result = 32'h11111111; exe_flags = 0; settle;
    check("dep_ready", iss_ready, 1);
    check("dep_start", exe_start, 1);
    adv; clr_in; settle;
    check("dep_wren", fp_wren, 1);
    check("dep_waddr", fp_waddr, 6);
    check("dep_wdata", fp_wdata, 32'h11111111);
    // flush at cycle 4 of fdiv: late exe_ready ignored, scoreboard cleared
    adv; issue(1, 0, 5, 3'b011, 1, 2, 0, 1); settle;
    for (int c = 1; c <= 13; c++) begin
      adv; clr_in; iss_rden = 3'b001; iss_raddr1 = 5;
      flush = (c == 4); exe_ready = (c == 12);
      settle;
      check("fl_wren", fp_wren, 0);
      if (c >= 5) begin
        check("fl_busy", busy, 0);
        check("fl_sb_clear", iss_ready, 1);
      end
    end
    exe_ready = 0; clr_in;
    // feq x7: integer write-back and accrued fflags
    adv; issue(0, 1, 7, 3'b011, 1, 2, 1, 0); exe_result = 1; exe_flags = 5'b10000; csr_fflags_cur = 5'b00001; settle;
    check("feq_start", exe_start, 1);
    check("feq_csr_idle", csr_fpu, 0);
    adv; clr_in; exe_flags = 0; settle;
    check("feq_int_wren", int_wren, 1);
    check("feq_int_waddr", int_waddr, 7);
    check("feq_int_wdata", int_wdata, 1);
    check("feq_fp_wren", fp_wren, 0);
    check("feq_csr", csr_fpu, 1);
    check("feq_fflags", csr_fflags, 5'b10001);
    adv; settle;
    check("feq_csr_off", csr_fpu, 0);
    // f0 is a valid FP destination
    adv; issue(1, 0, 0, 3'b000, 0, 0, 0, 0); exe_result = 32'h0000abcd; settle;
    adv; clr_in; settle;
    check("f0_wren", fp_wren, 1);
    check("f0_waddr", fp_waddr, 0);
    check("f0_wdata", fp_wdata, 32'h0000abcd);
    // timeout: err on 8th WAIT cycle only, stay in WAIT until flush
    adv; issue(1, 0, 9, 3'b000, 0, 0, 0, 1); settle;
    for (int c = 1; c <= 12; c++) begin
      adv; clr_in; flush = (c == 12); settle;
      check("to_err", err, (c == 8) ? 1 : 0);
      check("to_busy", busy, 1);
    end
    adv; flush = 0; exe_ready = 1; settle;
    check("to_flush_busy", busy, 0);
    adv; exe_ready = 0; settle;
    check("to_ignored_busy", busy, 0);
    check("to_ignored_wren", fp_wren, 0);
    // reset mid-WAIT discards the op and its scoreboard bit
    adv; issue(1, 0, 9, 3'b000, 0, 0, 0, 1); settle;
    adv; clr_in;
    adv; reset = 1; settle;
    check("rw_rst_ready", iss_ready, 0);
    adv; reset = 0; exe_ready = 1; iss_rden = 3'b001; iss_raddr1 = 9; settle;
    check("rw_busy", busy, 0);
    check("rw_sb_clear", iss_ready, 1);
    adv; exe_ready = 0; settle;
    check("rw_wren", fp_wren, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
